a2d_spi_resp: RTL and testbench

//  SPI responder (slave) behaving as the 8-channel 12-bit A2D converter that the A2D master interface talks to.

---
 rtl/a2d_spi_resp_pkg.sv | 26 ++
 rtl/a2d_spi_resp_if.sv | 17 +
 rtl/a2d_spi_resp_sync.sv | 43 ++++
 rtl/a2d_spi_resp.sv | 157 +++++++++++++++
 tb/tb_a2d_spi_resp.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/a2d_spi_resp_pkg.sv
// +--------------------------------------------------------------------+
// | a2d_pkg : shared types and helpers for the A2D SPI responder      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } resp_state_t;

    localparam int A2D_FRM_W = 16;
    localparam int CHNL_MSB  = 13;
    localparam int CHNL_LSB  = 11;
    localparam int CHNL_W    = CHNL_MSB - CHNL_LSB + 1;

    function automatic logic [A2D_FRM_W-1:0] a2d_cmd(input logic [CHNL_W-1:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_spi_resp_if.sv
// +--------------------------------------------------------------------+
// | a2d_spi_resp_if : 4-wire SPI bus between A2D master and responder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

`default_nettype wire

// File: rtl/a2d_spi_resp_sync.sv
// +--------------------------------------------------------------------+
// | spi_edge_sync : SYNC_STG-flop synchronizer plus edge detector     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_edge_sync #(
    parameter int   SYNC_STG = 2,
    parameter logic RST_VAL  = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      lvl,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], din};
        prev_d = sync_q[SYNC_STG-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STG{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl  = sync_q[SYNC_STG-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

`default_nettype wire

// File: rtl/a2d_spi_resp.sv
// +--------------------------------------------------------------------+
// | a2d_spi_resp : SPI slave model of an 8-ch 12-bit A2D, pipelined   |
// | read. A2D_PTRN_EN replaces ch_val with per-channel counters.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int RES_W    = 12,
    parameter int SYNC_STG = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    a2d_spi_resp_if.slave                spi,
    input  wire logic [NUM_CH*RES_W-1:0] ch_val,
    output logic                         cmd_rdy,
    output logic [CHNL_W-1:0]            cmd_chnl,
    output logic                         frm_err
);

    localparam int MAX_CH = 1 << CHNL_W;

    logic ss_lvl, ss_rise, ss_fall_unused;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(spi.SS_n),
        .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall_unused));

    spi_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(spi.SCLK),
        .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));

    spi_edge_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(spi.MOSI),
        .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    resp_state_t            state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [A2D_FRM_W-1:0]   tx_q, tx_d;
    logic [A2D_FRM_W-1:0]   rx_q, rx_d;
    logic [CHNL_W-1:0]      cmd_chnl_q, cmd_chnl_d;
    logic [RES_W-1:0]       src [MAX_CH];
    logic                   frm_start;

    assign frm_start = (state_q == IDLE) && !ss_lvl;

`ifdef A2D_PTRN_EN
    logic [RES_W-1:0]  ptrn_q [NUM_CH];
    logic [RES_W-1:0]  ptrn_d [NUM_CH];
    logic [CHNL_W-1:0] ld_chnl_q, ld_chnl_d;

    assign ld_chnl_d = frm_start ? cmd_chnl_q : ld_chnl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ld_chnl_q <= '0;
        else     ld_chnl_q <= ld_chnl_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ptrn
        // Only the counter that was just returned advances on a good frame.
        assign ptrn_d[i] = ptrn_q[i] +
            RES_W'((cmd_rdy && ld_chnl_q == CHNL_W'(i)) ? 1 : 0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) ptrn_q[i] <= RES_W'(i) << (RES_W - CHNL_W);
            else     ptrn_q[i] <= ptrn_d[i];
        end
    end
`endif

    for (genvar i = 0; i < MAX_CH; i++) begin : g_src
        if (i < NUM_CH) begin : g_live
`ifdef A2D_PTRN_EN
            assign src[i] = ptrn_q[i];
`else
            assign src[i] = ch_val[i*RES_W +: RES_W];
`endif
        end else begin : g_zero
            assign src[i] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cmd_chnl_d = cmd_chnl_q;
        cmd_rdy    = 1'b0;
        frm_err    = 1'b0;
        case (state_q)
            IDLE: begin
                // Level test so an SS_n fall seen during DONE is still taken.
                if (frm_start) begin
                    tx_d      = A2D_FRM_W'(src[cmd_chnl_q]);
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[A2D_FRM_W-2:0], mosi_lvl};
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                    tx_d = {tx_q[A2D_FRM_W-2:0], 1'b0};
                end
            end
            DONE: begin
                if (bit_cnt_q == 5'(A2D_FRM_W)) begin
                    cmd_chnl_d = rx_q[CHNL_MSB:CHNL_LSB];
                    cmd_rdy    = 1'b1;
                end else begin
                    frm_err = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cmd_chnl_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cmd_chnl_q <= cmd_chnl_d;
        end
    end

    assign spi.MISO = (state_q == SHIFT) ? tx_q[A2D_FRM_W-1] : 1'b0;
    assign cmd_chnl = cmd_chnl_q;

    logic sink_unused;
    assign sink_unused = ^{ss_fall_unused, sclk_lvl_unused, mosi_rise_unused,
                           mosi_fall_unused, rx_q[15:14], rx_q[10:0]
`ifdef A2D_PTRN_EN
                           , ch_val
`endif
                          };

endmodule

`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
// +--------------------------------------------------------------------+
// | tb_a2d_spi_resp : scoreboard bench for the A2D SPI responder      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_a2d_spi_resp;
    import a2d_pkg::*;

    localparam int NUM_CH = 8;
    localparam int RES_W  = 12;
    localparam int HALF   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a2d_spi_resp_if spi();

    logic [NUM_CH*RES_W-1:0] ch_val;
    logic                    cmd_rdy;
    logic [2:0]              cmd_chnl;
    logic                    frm_err;

    a2d_spi_resp #(.NUM_CH(NUM_CH), .RES_W(RES_W), .SYNC_STG(2)) dut (
        .clk(clk), .rst(rst), .spi(spi), .ch_val(ch_val),
        .cmd_rdy(cmd_rdy), .cmd_chnl(cmd_chnl), .frm_err(frm_err));

    int n_assert = 0;
    int n_fail   = 0;
    int rdy_cnt  = 0;
    int err_cnt  = 0;

    logic [15:0] exp_q [$];
    logic [2:0]  mdl_chnl = 3'd0;
    logic [11:0] ptrn [NUM_CH];

    always @(negedge clk) begin
        if (cmd_rdy) rdy_cnt++;
        if (frm_err) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] chv_of(input logic [2:0] c);
        return ch_val[int'(c)*RES_W +: RES_W];
    endfunction

    task automatic spi_bit(input logic b, output logic m);
        spi.SCLK = 1'b0;
        spi.MOSI = b;
        clk_n(HALF);
        m = spi.MISO;
        spi.SCLK = 1'b1;
        clk_n(HALF);
    endtask

    task automatic frame(input logic [2:0] c, input int nbits, output logic [15:0] w);
        logic [15:0] cmd;
        logic        m;
        cmd = a2d_cmd(c);
        w   = '0;
        spi.SS_n = 1'b0;
        clk_n(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(cmd[15-i], m);
            w = {w[14:0], m};
        end
        spi.SS_n = 1'b1;
        clk_n(HALF);
    endtask

    task automatic full_frame(input logic [2:0] c);
        logic [15:0] w;
        int          r0;
        int          e0;
`ifdef A2D_PTRN_EN
        exp_q.push_back({4'h0, ptrn[mdl_chnl]});
        ptrn[mdl_chnl] = ptrn[mdl_chnl] + 12'd1;
`else
        exp_q.push_back({4'h0, chv_of(mdl_chnl)});
`endif
        r0 = rdy_cnt;
        e0 = err_cnt;
        frame(c, 16, w);
        mdl_chnl = c;
        check_eq($sformatf("resp(cmd%0d)", c), w, exp_q.pop_front());
        check_eq($sformatf("rdy_pulse(cmd%0d)", c), rdy_cnt - r0, 1);
        check_eq($sformatf("no_err(cmd%0d)", c), err_cnt - e0, 0);
        check_eq($sformatf("cmd_chnl(cmd%0d)", c), cmd_chnl, mdl_chnl);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        logic        m;
        int          r0;
        int          e0;

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_val[i*RES_W +: RES_W] = 12'(12'h100 * i + i);
            ptrn[i] = 12'(i) << 9;
        end
        ch_val[0 +: RES_W]       = 12'h0F0;
        ch_val[3*RES_W +: RES_W] = 12'hA5C;
        rst = 1'b1;
        clk_n(3);
        check_eq("rst_miso", spi.MISO, 0);
        check_eq("rst_cmd_rdy", cmd_rdy, 0);
        check_eq("rst_frm_err", frm_err, 0);
        check_eq("rst_cmd_chnl", cmd_chnl, 0);
        rst = 1'b0;
        clk_n(4);

`ifdef A2D_PTRN_EN
        for (int k = 0; k < 4; k++) full_frame(3'd5);
`else
        // Pipelined read: first response is channel 0, then the prior command's channel.
        full_frame(3'd3);
        full_frame(3'd0);

        for (int i = 0; i < NUM_CH; i++) ch_val[i*RES_W +: RES_W] = 12'(12'h100 * i + i);
        for (int c = 0; c < NUM_CH; c++) full_frame(3'(c));

        r0 = rdy_cnt;
        e0 = err_cnt;
        frame(3'd5, 9, w);
        check_eq("short_err_pulse", err_cnt - e0, 1);
        check_eq("short_no_rdy", rdy_cnt - r0, 0);
        check_eq("short_chnl_kept", cmd_chnl, mdl_chnl);
        full_frame(3'd4);

        r0 = rdy_cnt;
        e0 = err_cnt;
        spi.SS_n = 1'b0;
        clk_n(HALF);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        rst = 1'b1;
        #1;
        check_eq("midrst_miso", spi.MISO, 0);
        check_eq("midrst_chnl", cmd_chnl, 0);
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        clk_n(4);
        rst = 1'b0;
        clk_n(HALF);
        check_eq("midrst_no_rdy", rdy_cnt - r0, 0);
        check_eq("midrst_no_err", err_cnt - e0, 0);
        mdl_chnl = 3'd0;
        full_frame(3'd6);
        full_frame(3'd6);

        ch_val[2*RES_W +: RES_W] = 12'h111;
        full_frame(3'd2);
        fork
            full_frame(3'd2);
            begin
                clk_n(HALF * 10);
                ch_val[2*RES_W +: RES_W] = 12'h222;
            end
        join
        full_frame(3'd1);
`endif

        check_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
